// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: register-bus controller for the bidirectional pad ring.
// Holds per-pad configuration that drives the pad control lines. Synchronises
// the pad inputs and latches selected edges into W1C pending flags, which are
// ORed into a level interrupt.
// Ports:
//   clk, rst             core clock, synchronous active-high reset
//   bus_req/we/addr/wdata  simple request bus; bus_ack pulses one cycle later
//   bus_rdata            read data, zero outside the ack cycle
//   bidir_in             raw pad inputs
//   bidir_out/oe/cs/sl/ie/pu/pd  per-pad drive and control lines
//   irq                  OR of all pending edge flags
module gpio_pad_ctrl #(
  parameter int unsigned NUM_PADS = 37
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bus_req,
  input  logic                bus_we,
  input  logic [7:0]          bus_addr,
  input  logic [31:0]         bus_wdata,
  output logic [31:0]         bus_rdata,
  output logic                bus_ack,
  input  logic [NUM_PADS-1:0] bidir_in,
  output logic [NUM_PADS-1:0] bidir_out,
  output logic [NUM_PADS-1:0] bidir_oe,
  output logic [NUM_PADS-1:0] bidir_cs,
  output logic [NUM_PADS-1:0] bidir_sl,
  output logic [NUM_PADS-1:0] bidir_ie,
  output logic [NUM_PADS-1:0] bidir_pu,
  output logic [NUM_PADS-1:0] bidir_pd,
  output logic                irq
);

  localparam int unsigned CFG_W = 10;
  localparam logic [CFG_W-1:0] CFG_RST  = 10'h004;
  localparam logic [CFG_W-1:0] CFG_MASK = 10'h37F;
  localparam logic [7:0] ADDR_IN_LO   = 8'h40;
  localparam logic [7:0] ADDR_IN_HI   = 8'h41;
  localparam logic [7:0] ADDR_PEND_LO = 8'h42;
  localparam logic [7:0] ADDR_PEND_HI = 8'h43;

  typedef enum logic {ST_IDLE, ST_ACK} state_e;

  state_e              state_q;
  logic                ack_q;
  logic [31:0]         rdata_q;
  logic [CFG_W-1:0]    cfg_q [NUM_PADS];
  logic [NUM_PADS-1:0] meta_q, sync_q, prev_q, pend_q, pend_d;

  logic                accept, wr_en;
  logic [NUM_PADS-1:0] cfg_sel, clr, rise_ev, fall_ev;
  logic [31:0]         cfg_rd, rd_data;
  logic [63:0]         sync_ext, pend_ext;

  assign accept   = (state_q == ST_IDLE) && bus_req;
  assign wr_en    = accept && bus_we;
  assign sync_ext = 64'(sync_q);
  assign pend_ext = 64'(pend_q);

  // Address decode for the CFG window and its readback value
  always_comb begin
    cfg_sel = '0;
    cfg_rd  = '0;
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      if (bus_addr == 8'(i)) begin
        cfg_sel[i] = 1'b1;
        cfg_rd     = 32'(cfg_q[i]);
      end
    end
  end

  // Read mux; unmapped addresses fall through to cfg_rd, which is zero there
  always_comb begin
    case (bus_addr)
      ADDR_IN_LO:   rd_data = sync_ext[31:0];
      ADDR_IN_HI:   rd_data = sync_ext[63:32];
      ADDR_PEND_LO: rd_data = pend_ext[31:0];
      ADDR_PEND_HI: rd_data = pend_ext[63:32];
      default:      rd_data = cfg_rd;
    endcase
  end

  // Edge detection, W1C clear and pending update (a new event beats a clear)
  always_comb begin
    clr     = '0;
    rise_ev = '0;
    fall_ev = '0;
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      clr[i]     = wr_en && bus_wdata[5'(i)] &&
                   ((i < 32) ? (bus_addr == ADDR_PEND_LO) : (bus_addr == ADDR_PEND_HI));
      rise_ev[i] = cfg_q[i][8] && sync_q[i] && !prev_q[i];
      fall_ev[i] = cfg_q[i][9] && !sync_q[i] && prev_q[i];
    end
    pend_d = (pend_q & ~clr) | rise_ev | fall_ev;
  end

  // Pad lines straight from the config bits; pull-down overrides pull-up
  always_comb begin
    bidir_out = '0;
    bidir_oe  = '0;
    bidir_ie  = '0;
    bidir_cs  = '0;
    bidir_sl  = '0;
    bidir_pu  = '0;
    bidir_pd  = '0;
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      bidir_out[i] = cfg_q[i][0];
      bidir_oe[i]  = cfg_q[i][1];
      bidir_ie[i]  = cfg_q[i][2];
      bidir_cs[i]  = cfg_q[i][3];
      bidir_sl[i]  = cfg_q[i][4];
      bidir_pu[i]  = cfg_q[i][5] && !cfg_q[i][6];
      bidir_pd[i]  = cfg_q[i][6];
    end
  end

  assign irq       = |pend_q;
  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;

  // Bus FSM: accept in IDLE, present ack/rdata for exactly one cycle in ACK
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_req) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            rdata_q <= bus_we ? 32'd0 : rd_data;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  // Config storage, input synchroniser and pending flags
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
      for (int unsigned i = 0; i < NUM_PADS; i++) begin
        cfg_q[i] <= CFG_RST;
      end
    end else begin
      meta_q <= bidir_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      pend_q <= pend_d;
      for (int unsigned i = 0; i < NUM_PADS; i++) begin
        if (wr_en && cfg_sel[i]) begin
          cfg_q[i] <= bus_wdata[CFG_W-1:0] & CFG_MASK;
        end
      end
    end
  end

endmodule
